// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-scan activation stream.
// Optional MAXPOOL_FRAME_DONE_EN adds a frame_done pulse on the last window of each frame.
module max_pool_2x2 #(
  parameter int DATA_WIDTH = 22,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pixel_valid,
  input  logic signed [DATA_WIDTH-1:0] pixel_in,
  output logic                         result_valid,
  output logic signed [DATA_WIDTH-1:0] result_out
`ifdef MAXPOOL_FRAME_DONE_EN
  ,
  output logic                         frame_done
`endif
);

  localparam int CW   = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW   = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int HALF = IMG_WIDTH / 2;
  localparam int LBW  = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]                col_cnt;
  logic [RW-1:0]                row_cnt;
  logic signed [DATA_WIDTH-1:0] pair_q;
  logic signed [DATA_WIDTH-1:0] line_buf [HALF];

  logic                         col_last;
  logic                         row_last;
  logic [LBW-1:0]               lb_idx;
  logic signed [DATA_WIDTH-1:0] lb_rd;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] win_max;
  logic                         lb_we;
  logic                         win_done;

  assign col_last = (col_cnt == CW'(IMG_WIDTH - 1));
  assign row_last = (row_cnt == RW'(IMG_HEIGHT - 1));
  assign lb_idx   = LBW'(col_cnt >> 1);
  assign lb_rd    = line_buf[lb_idx];
  assign pair_max = (pair_q > pixel_in) ? pair_q : pixel_in;
  assign win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;

  always_comb begin
    state_d  = state_q;
    lb_we    = 1'b0;
    win_done = 1'b0;
    if (pixel_valid && col_cnt[0]) begin
      if (state_q == EVEN_ROW) lb_we    = 1'b1;
      else                     win_done = 1'b1;
    end
    if (pixel_valid && col_last) begin
      state_d = (row_last || state_q == ODD_ROW) ? EVEN_ROW : ODD_ROW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EVEN_ROW;
      col_cnt      <= '0;
      row_cnt      <= '0;
      pair_q       <= '0;
      result_valid <= 1'b0;
      result_out   <= '0;
    end else begin
      state_q      <= state_d;
      result_valid <= win_done;
      if (win_done) result_out <= win_max;
      if (pixel_valid) begin
        if (!col_cnt[0]) pair_q <= pixel_in;
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  // Contents need no reset: every even row rewrites each entry before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) line_buf[lb_idx] <= pair_max;
  end

`ifdef MAXPOOL_FRAME_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_done <= 1'b0;
    else      frame_done <= win_done && col_last && row_last;
  end
`endif

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2 on a 4x4 frame: table of frames plus a mid-frame reset sequence.
module tb_max_pool_2x2;

  localparam int DW = 22;
  localparam int W  = 4;
  localparam int H  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 pixel_valid = 1'b0;
  logic signed [DW-1:0] pixel_in = '0;
  logic                 result_valid;
  logic signed [DW-1:0] result_out;
`ifdef MAXPOOL_FRAME_DONE_EN
  logic                 frame_done;
`endif

  max_pool_2x2 #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .result_valid(result_valid),
    .result_out  (result_out)
`ifdef MAXPOOL_FRAME_DONE_EN
    ,
    .frame_done  (frame_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0][DW-1:0] pix;
    logic [3:0][DW-1:0]  exp;
    logic [7:0]          gap;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  int                   total = 0;
  int                   bad   = 0;
  logic signed [DW-1:0] last_out = '0;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic check_outputs(input bit br, input logic signed [DW-1:0] ex, input bit fd_exp);
    chk("result_valid", longint'(result_valid), longint'(br));
    if (br) begin
      chk("result_out", longint'(result_out), longint'(ex));
      last_out = ex;
    end else begin
      chk("result_hold", longint'(result_out), longint'(last_out));
    end
`ifdef MAXPOOL_FRAME_DONE_EN
    chk("frame_done", longint'(frame_done), longint'(fd_exp));
`else
    if (fd_exp) begin end
`endif
  endtask

  task automatic send(input logic signed [DW-1:0] v, input bit br,
                      input logic signed [DW-1:0] ex, input bit fd_exp);
    pixel_valid = 1'b1;
    pixel_in    = v;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    check_outputs(br, ex, fd_exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_outputs(1'b0, '0, 1'b0);
    end
  endtask

  task automatic run_frame(input vec_t t);
    for (int i = 0; i < W * H; i++) begin
      int r, c, win;
      bit br;
      r   = i / W;
      c   = i % W;
      br  = (r % 2 == 1) && (c % 2 == 1);
      win = (r / 2) * (W / 2) + (c / 2);
      send($signed(t.pix[i]), br, $signed(t.exp[win]), br && (i == W * H - 1));
      if (t.gap != 0) idle(int'($urandom_range(0, int'(t.gap))));
    end
  endtask

  function automatic logic [DW-1:0] v22(input int x);
    return DW'(x);
  endfunction

  initial begin
    // Build the frame table: each pixel's window and position within it drive its value.
    for (int i = 0; i < W * H; i++) begin
      int r, c, win, pos;
      r   = i / W;
      c   = i % W;
      win = (r / 2) * (W / 2) + (c / 2);
      pos = (r % 2) * 2 + (c % 2);
      tbl[0].pix[i] = v22(i);
      tbl[1].pix[i] = v22(16 + i);
      for (int k = 0; k < 4; k++)
        tbl[2 + k].pix[i] = v22((pos == k) ? 9 : ((pos < k) ? pos + 1 : pos));
      if (win == 1) begin
        case (pos)
          0: tbl[6].pix[i] = v22(-5);
          1: tbl[6].pix[i] = v22(-2);
          2: tbl[6].pix[i] = v22(-7);
          default: tbl[6].pix[i] = v22(-3);
        endcase
      end else begin
        tbl[6].pix[i] = v22(-1);
      end
      tbl[7].pix[i] = v22(i);
      case (win)
        0: case (pos)
             0: tbl[8].pix[i] = v22(-2097152);
             1: tbl[8].pix[i] = v22(2097151);
             2: tbl[8].pix[i] = v22(0);
             default: tbl[8].pix[i] = v22(-1);
           endcase
        1: tbl[8].pix[i] = v22(-2097152);
        2: tbl[8].pix[i] = v22(7);
        default: tbl[8].pix[i] = v22((pos == 2) ? -4 : -3);
      endcase
    end
    tbl[0].exp = {v22(15), v22(13), v22(7), v22(5)};
    tbl[1].exp = {v22(31), v22(29), v22(23), v22(21)};
    for (int k = 2; k < 6; k++) tbl[k].exp = {v22(9), v22(9), v22(9), v22(9)};
    tbl[6].exp = {v22(-1), v22(-1), v22(-2), v22(-1)};
    tbl[7].exp = tbl[0].exp;
    tbl[8].exp = {v22(-3), v22(7), v22(-2097152), v22(2097151)};
    for (int k = 0; k < NV; k++) tbl[k].gap = (k == 7) ? 8'd5 : 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0, '0, 1'b0);
    rst = 1'b1;
    idle(2);

    for (int k = 0; k < NV; k++) run_frame(tbl[k]);
    idle(3);

    // Mid-frame reset: the 6th pixel closes window 0, so 100 is legitimately emitted once.
    for (int i = 0; i < 6; i++) send(v22(100), i == 5, v22(100), 1'b0);
    rst         = 1'b0;
    pixel_valid = 1'b1;
    pixel_in    = v22(100);
    #1;
    last_out = '0;
    check_outputs(1'b0, '0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_outputs(1'b0, '0, 1'b0);
    end
    pixel_valid = 1'b0;
    rst         = 1'b1;
    idle(1);
    run_frame(tbl[0]);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
